// File: rtl/bo_mult_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : bo_mult_datapath
//  Description : Operative block of the successive-addition multiplier.
//                Holds the multiplicand (opr), a down-counter loaded with the
//                multiplier (cnt) and a 2*WIDTH accumulator that adds opr once
//                per cac strobe. The control block drives set/rac/cac/dec and
//                watches zero; the product is presented on p.
//  Ports       : clk, rst         - clock, synchronous active-high reset
//                a, b             - multiplicand / multiplier, sampled on set
//                set, rac, cac, dec - control strobes (load, clear acc,
//                                   accumulate, decrement)
//                zero             - counter == 0 (combinational)
//                p                - accumulator contents (product)
//                ovf              - sticky overflow flag, only present when
//                                   BO_MULT_OVF_EN is defined
//  Options     : `define BO_MULT_OVF_EN adds the ovf output.
//  Revision    : 1.0 - initial release
// ============================================================================
module bo_mult_datapath #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 set,
    input  logic                 rac,
    input  logic                 cac,
    input  logic                 dec,
    output logic                 zero,
`ifdef BO_MULT_OVF_EN
    output logic                 ovf,
`endif
    output logic [2*WIDTH-1:0]   p
);

    logic [WIDTH-1:0]   r_opr;
    logic [WIDTH-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic               w_cnt_zero;
    // One extra bit so the carry out of the accumulator add is visible.
    logic [2*WIDTH:0]   w_sum;

    assign w_cnt_zero = (r_cnt == '0);
    assign w_sum      = {1'b0, r_acc} + {{(WIDTH+1){1'b0}}, r_opr};

    // Operand and counter. set takes priority over dec; dec saturates at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opr <= '0;
            r_cnt <= '0;
        end else if (set) begin
            r_opr <= a;
            r_cnt <= b;
        end else if (dec && !w_cnt_zero) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    // Accumulator. rac takes priority over cac; the add wraps modulo 2^(2W).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (rac) begin
            r_acc <= '0;
        end else if (cac) begin
            r_acc <= w_sum[2*WIDTH-1:0];
        end
    end

`ifdef BO_MULT_OVF_EN
    logic r_ovf;

    // Sticky flag: carry out of an accumulate, or a decrement of an empty
    // counter. set clears it and wins over a same-cycle setting event.
    always_ff @(posedge clk) begin
        if (rst || set) begin
            r_ovf <= 1'b0;
        end else if ((cac && !rac && w_sum[2*WIDTH]) || (dec && w_cnt_zero)) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`endif

    assign zero = w_cnt_zero;
    assign p    = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_bo_mult_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bo_mult_datapath
//  Description : Self-checking bench for bo_mult_datapath (WIDTH = 8).
//                A behavioural model tracks operand, counter, accumulator and
//                overflow with plain integer arithmetic; a negedge process
//                compares zero/p (and ovf when enabled) every cycle, and
//                directed scenarios add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bo_mult_datapath;

    localparam int WIDTH = 8;
    localparam longint c_mod = 64'd1 << (2*WIDTH);

    logic               clk;
    logic               rst;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               set;
    logic               rac;
    logic               cac;
    logic               dec;
    logic               zero;
    logic [2*WIDTH-1:0] p;
`ifdef BO_MULT_OVF_EN
    logic               ovf;
`endif

    bo_mult_datapath #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .set  (set),
        .rac  (rac),
        .cac  (cac),
        .dec  (dec),
        .zero (zero),
`ifdef BO_MULT_OVF_EN
        .ovf  (ovf),
`endif
        .p    (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    bit chk_en   = 1'b0;

    // Behavioural model state
    longint m_opr = 0;
    longint m_cnt = 0;
    longint m_acc = 0;
    bit     m_ovf = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Next-state of the multiplier datapath from its functional rules.
    task automatic model_step(input bit r, input bit s, input bit ra, input bit ca,
                              input bit de, input longint av, input longint bv);
        longint n_acc;
        longint n_cnt;
        bit     n_ovf;
        if (r) begin
            m_opr = 0; m_cnt = 0; m_acc = 0; m_ovf = 1'b0;
            return;
        end
        n_acc = m_acc;
        n_cnt = m_cnt;
        n_ovf = m_ovf;
        if (ra) n_acc = 0;
        else if (ca) begin
            if (m_acc + m_opr >= c_mod) n_ovf = 1'b1;
            n_acc = (m_acc + m_opr) % c_mod;
        end
        if (de && m_cnt == 0) n_ovf = 1'b1;
        if (s) begin
            n_cnt = bv;
            n_ovf = 1'b0;
            m_opr = av;
        end else if (de && m_cnt > 0) begin
            n_cnt = m_cnt - 1;
        end
        m_acc = n_acc;
        m_cnt = n_cnt;
        m_ovf = n_ovf;
    endtask

    // One clock: drive strobes, advance model on the edge, return at negedge.
    task automatic cyc(input bit r, input bit s, input bit ra, input bit ca,
                       input bit de, input logic [WIDTH-1:0] av,
                       input logic [WIDTH-1:0] bv);
        rst = r; set = s; rac = ra; cac = ca; dec = de; a = av; b = bv;
        @(posedge clk);
        model_step(r, s, ra, ca, de, longint'(av), longint'(bv));
        @(negedge clk);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("zero_model", longint'(zero), (m_cnt == 0) ? 1 : 0);
            chk("p_model", longint'(p), m_acc);
`ifdef BO_MULT_OVF_EN
            chk("ovf_model", longint'(ovf), longint'(m_ovf));
`endif
        end
    end

    initial begin
        rst = 1'b0; set = 1'b0; rac = 1'b0; cac = 1'b0; dec = 1'b0;
        a = '0; b = '0;
        @(negedge clk);

        // 1. Reset with every strobe high
        cyc(1, 1, 1, 1, 1, 8'hFF, 8'hFF);
        chk_en = 1'b1;
        chk("rst_p", longint'(p), 0);
        chk("rst_zero", longint'(zero), 1);

        // 2. 5 x 3
        cyc(0, 1, 1, 0, 0, 8'd5, 8'd3);
        chk("m53_zero0", longint'(zero), 0);
        cyc(0, 0, 0, 1, 1, 8'd0, 8'd0);
        chk("m53_zero1", longint'(zero), 0);
        cyc(0, 0, 0, 1, 1, 8'd0, 8'd0);
        chk("m53_zero2", longint'(zero), 0);
        cyc(0, 0, 0, 1, 1, 8'd0, 8'd0);
        chk("m53_zero3", longint'(zero), 1);
        chk("m53_p", longint'(p), 15);

        // Idle: everything holds
        cyc(0, 0, 0, 0, 0, 8'hAA, 8'h55);
        chk("hold_p", longint'(p), 15);

        // 3. 255 x 255
        cyc(0, 1, 1, 0, 0, 8'd255, 8'd255);
        for (int i = 0; i < 255; i++) cyc(0, 0, 0, 1, 1, 8'd0, 8'd0);
        chk("max_p", longint'(p), 64'hFE01);
        chk("max_zero", longint'(zero), 1);
`ifdef BO_MULT_OVF_EN
        chk("max_ovf", longint'(ovf), 0);
`endif

        // Accumulator wrap: FE01 + 3*FF = 0x100FE -> 0x00FE
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 8'd0, 8'd0);
        chk("wrap_p", longint'(p), 64'h00FE);
`ifdef BO_MULT_OVF_EN
        chk("wrap_ovf", longint'(ovf), 1);
`endif

        // 4. b = 0, then dec on an empty counter
        cyc(0, 1, 0, 0, 0, 8'd9, 8'd0);
        chk("b0_zero", longint'(zero), 1);
`ifdef BO_MULT_OVF_EN
        chk("b0_ovf_clr", longint'(ovf), 0);
`endif
        cyc(0, 0, 0, 0, 1, 8'd0, 8'd0);
        chk("b0_dec1_zero", longint'(zero), 1);
`ifdef BO_MULT_OVF_EN
        chk("b0_dec1_ovf", longint'(ovf), 1);
`endif
        cyc(0, 0, 0, 0, 1, 8'd0, 8'd0);
        chk("b0_dec2_zero", longint'(zero), 1);
        cyc(0, 1, 0, 0, 1, 8'd9, 8'd0);
`ifdef BO_MULT_OVF_EN
        chk("b0_set_ovf", longint'(ovf), 0);
`endif

        // 5. Simultaneous strobes
        cyc(0, 1, 0, 0, 0, 8'd4, 8'd2);
        cyc(0, 0, 0, 1, 0, 8'd0, 8'd0);
        chk("sim_pre_p", longint'(p), 64'h0102);
        cyc(0, 0, 1, 1, 0, 8'd0, 8'd0);
        chk("sim_racwin_p", longint'(p), 0);
        cyc(0, 1, 0, 0, 1, 8'd4, 8'd7);
        chk("sim_setwin_zero", longint'(zero), 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1, 8'd0, 8'd0);
        chk("sim_cnt1_zero", longint'(zero), 0);
        cyc(0, 0, 0, 0, 1, 8'd0, 8'd0);
        chk("sim_cnt0_zero", longint'(zero), 1);

        // 6. Reset mid-operation
        cyc(0, 1, 1, 0, 0, 8'd6, 8'd4);
        cyc(0, 0, 0, 1, 1, 8'd0, 8'd0);
        cyc(0, 0, 0, 1, 1, 8'd0, 8'd0);
        chk("mid_p", longint'(p), 12);
        chk("mid_zero", longint'(zero), 0);
        cyc(1, 1, 0, 1, 1, 8'd33, 8'd44);
        chk("mid_rst_p", longint'(p), 0);
        chk("mid_rst_zero", longint'(zero), 1);
        cyc(0, 0, 0, 1, 0, 8'd0, 8'd0);
        chk("post_rst_opr0_p", longint'(p), 0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
